// File: rtl/free_list_mp_pkg.sv
// Shared sizing constants for the rename-stage physical register free list.
package free_list_mp_pkg;
  localparam int PHYS_REG_SZ     = 64;
  localparam int PHYS_REG_IDX_SZ = $clog2(PHYS_REG_SZ);
endpackage

// File: rtl/free_list_mp_multi_prio_enc.sv
// Returns the K lowest set-bit indices of an N-bit vector, each with a valid bit.
module multi_prio_enc #(
  parameter int N = 8,
  parameter int K = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0]        vec,
  output logic [K-1:0]        valid,
  output logic [K-1:0][W-1:0] idx
);
  logic [N-1:0] rem;
  logic         found;

  // Each pass picks the lowest remaining bit and removes it for the next pass.
  always_comb begin
    rem   = vec;
    valid = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = 0; k < K; k++) begin
      found = 1'b0;
      for (int n = 0; n < N; n++) begin
        if (!found && rem[n]) begin
          found    = 1'b1;
          valid[k] = 1'b1;
          idx[k]   = W'(n);
        end
      end
      if (found) rem[idx[k]] = 1'b0;
    end
  end
endmodule

// File: rtl/free_list_mp.sv
// Multi-port physical register free list: bitmap storage (1 = free), in-order
// allocation, multi-port free, and a single branch checkpoint.
module free_list_mp
  import free_list_mp_pkg::*;
#(
  parameter int NUM_PR    = PHYS_REG_SZ,
  parameter int DEQ_WIDTH = 2,
  parameter int ENQ_WIDTH = 2,
  parameter int IDX_W     = $clog2(NUM_PR)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DEQ_WIDTH-1:0]            deq_req,
  output logic [DEQ_WIDTH-1:0]            deq_valid,
  output logic [DEQ_WIDTH-1:0][IDX_W-1:0] deq_pr,
  input  logic [ENQ_WIDTH-1:0]            enq_en,
  input  logic [ENQ_WIDTH-1:0][IDX_W-1:0] enq_pr,
  input  logic                            ckpt_en,
  input  logic                            restore_en,
  output logic [IDX_W:0]                  free_count,
  output logic                            is_empty,
  output logic                            double_free_err
);
  localparam logic [NUM_PR-1:0] RESET_MAP = {{(NUM_PR-1){1'b1}}, 1'b0};

  logic [NUM_PR-1:0]                 bitmap, snap;
  logic [NUM_PR-1:0]                 bitmap_n, snap_n;
  logic [NUM_PR-1:0]                 grant_bits, enq_bits, seen;
  logic [DEQ_WIDTH-1:0]              enc_valid;
  logic [DEQ_WIDTH-1:0][IDX_W-1:0]   enc_idx;
  logic [IDX_W:0]                    count_n;
  logic                              err_now;
  int                                slot;
  logic                              chain_ok;

  multi_prio_enc #(.N(NUM_PR), .K(DEQ_WIDTH), .W(IDX_W)) u_enc (
    .vec   (bitmap),
    .valid (enc_valid),
    .idx   (enc_idx)
  );

  // Handshake: a port allocates when deq_req and deq_valid are both high in a
  // cycle; the consumer takes deq_pr at that edge. There is no backpressure.
  always_comb begin
    deq_valid  = '0;
    deq_pr     = '0;
    grant_bits = '0;
    slot       = 0;
    chain_ok   = !reset && !restore_en;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (deq_req[i] && chain_ok) begin
        chain_ok = 1'b0;
        for (int k = 0; k < DEQ_WIDTH; k++) begin
          if (k == slot && enc_valid[k]) begin
            deq_valid[i] = 1'b1;
            deq_pr[i]    = enc_idx[k];
            chain_ok     = 1'b1;
          end
        end
        if (chain_ok) begin
          grant_bits[deq_pr[i]] = 1'b1;
          slot = slot + 1;
        end
      end
    end
  end

  // Frees: index 0 is dropped; a bit already free, or repeated across ports,
  // flags a double free without changing the result.
  always_comb begin
    enq_bits = '0;
    seen     = bitmap;
    err_now  = 1'b0;
    for (int j = 0; j < ENQ_WIDTH; j++) begin
      if (enq_en[j] && enq_pr[j] != '0) begin
        if (seen[enq_pr[j]]) err_now = 1'b1;
        seen[enq_pr[j]]     = 1'b1;
        enq_bits[enq_pr[j]] = 1'b1;
      end
    end
  end

  always_comb begin
    if (restore_en) bitmap_n = snap | enq_bits;
    else            bitmap_n = (bitmap & ~grant_bits) | enq_bits;
    // Retired frees are path-independent, so they also land in the snapshot.
    if (ckpt_en) snap_n = bitmap_n;
    else         snap_n = snap | enq_bits;
    count_n = '0;
    for (int n = 0; n < NUM_PR; n++) count_n = count_n + (IDX_W+1)'(bitmap_n[n]);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bitmap          <= RESET_MAP;
      snap            <= RESET_MAP;
      free_count      <= (IDX_W+1)'(NUM_PR - 1);
      double_free_err <= 1'b0;
    end else begin
      bitmap          <= bitmap_n;
      snap            <= snap_n;
      free_count      <= count_n;
      double_free_err <= double_free_err | err_now;
    end
  end

  assign is_empty = (free_count == '0);
endmodule

// File: tb/tb_free_list_mp.sv
// Directed bench for free_list_mp with NUM_PR=8, two allocate and two free ports.
module tb_free_list_mp;
  localparam int NUM_PR = 8;
  localparam int DW     = 2;
  localparam int EW     = 2;
  localparam int IW     = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [DW-1:0]          deq_req;
  logic [DW-1:0]          deq_valid;
  logic [DW-1:0][IW-1:0]  deq_pr;
  logic [EW-1:0]          enq_en;
  logic [EW-1:0][IW-1:0]  enq_pr;
  logic                   ckpt_en;
  logic                   restore_en;
  logic [IW:0]            free_count;
  logic                   is_empty;
  logic                   double_free_err;

  int errors = 0;
  int checks = 0;

  free_list_mp #(.NUM_PR(NUM_PR), .DEQ_WIDTH(DW), .ENQ_WIDTH(EW), .IDX_W(IW)) dut (
    .clk             (clk),
    .reset           (reset),
    .deq_req         (deq_req),
    .deq_valid       (deq_valid),
    .deq_pr          (deq_pr),
    .enq_en          (enq_en),
    .enq_pr          (enq_pr),
    .ckpt_en         (ckpt_en),
    .restore_en      (restore_en),
    .free_count      (free_count),
    .is_empty        (is_empty),
    .double_free_err (double_free_err)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Driver tasks: advance one edge and settle 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    deq_req    = '0;
    enq_en     = '0;
    enq_pr     = '0;
    ckpt_en    = 1'b0;
    restore_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    deq_req = 2'b11;
    #2;
    check("reset_deq_valid", deq_valid, 2'b00);
    check("reset_deq_pr0", deq_pr[0], 0);
    tick();
    #2 reset = 1'b0;
    #1;
    check("rst_count", free_count, 7);
    check("rst_empty", is_empty, 0);
    check("rst_err", double_free_err, 0);
    check("alloc2_valid", deq_valid, 2'b11);
    check("alloc2_pr0", deq_pr[0], 1);
    check("alloc2_pr1", deq_pr[1], 2);
    tick();
    check("alloc2_count", free_count, 5);

    // Gap in requests: only port 1 asks, takes the lowest free (3).
    deq_req = 2'b10;
    #1;
    check("gap_valid", deq_valid, 2'b10);
    check("gap_pr1", deq_pr[1], 3);
    check("gap_pr0", deq_pr[0], 0);
    tick();
    check("gap_count", free_count, 4);

    deq_req = 2'b11;
    #1;
    check("alloc45_pr0", deq_pr[0], 4);
    check("alloc45_pr1", deq_pr[1], 5);
    tick();
    check("alloc45_count", free_count, 2);

    // Checkpoint with {6,7} free.
    deq_req = 2'b00;
    ckpt_en = 1'b1;
    tick();
    ckpt_en = 1'b0;
    deq_req = 2'b11;
    #1;
    check("alloc67_pr0", deq_pr[0], 6);
    check("alloc67_pr1", deq_pr[1], 7);
    tick();
    check("drained_count", free_count, 0);
    check("drained_empty", is_empty, 1);
    #1;
    check("empty_valid", deq_valid, 2'b00);

    // Free 3 while empty.
    deq_req   = 2'b00;
    enq_en    = 2'b01;
    enq_pr[0] = 3'd3;
    tick();
    enq_en = '0;
    check("free3_count", free_count, 1);
    check("free3_empty", is_empty, 0);
    deq_req = 2'b11;
    #1;
    check("one_left_valid", deq_valid, 2'b01);
    check("one_left_pr0", deq_pr[0], 3);

    // Restore in the same cycle suppresses the grant.
    restore_en = 1'b1;
    #1;
    check("restore_valid", deq_valid, 2'b00);
    tick();
    restore_en = 1'b0;
    check("restore_count", free_count, 3);
    #1;
    check("post_restore_pr0", deq_pr[0], 3);
    check("post_restore_pr1", deq_pr[1], 6);

    // Free ordering: port 0 frees reg 0 (ignored), port 1 frees reg 5.
    deq_req   = 2'b00;
    enq_en    = 2'b11;
    enq_pr[0] = 3'd0;
    enq_pr[1] = 3'd5;
    tick();
    enq_en = '0;
    check("free5_count", free_count, 4);
    check("free5_err", double_free_err, 0);
    deq_req = 2'b11;
    #1;
    check("free5_pr1", deq_pr[1], 5);
    deq_req = 2'b00;

    // Freeing 5 again is a double free.
    enq_en    = 2'b10;
    enq_pr[1] = 3'd5;
    tick();
    enq_en = '0;
    check("dbl_err", double_free_err, 1);
    check("dbl_count", free_count, 4);
    tick();
    check("dbl_sticky", double_free_err, 1);

    // Same index on both ports counts once.
    enq_en    = 2'b11;
    enq_pr[0] = 3'd4;
    enq_pr[1] = 3'd4;
    tick();
    enq_en = '0;
    check("dup_count", free_count, 5);

    // Async reset mid-cycle after an allocation.
    deq_req = 2'b11;
    tick();
    check("pre_rst_count", free_count, 3);
    #2 reset = 1'b1;
    #1;
    check("async_count", free_count, 7);
    check("async_err", double_free_err, 0);
    check("async_valid", deq_valid, 2'b00);
    #1 reset = 1'b0;
    #1;
    check("after_rst_pr0", deq_pr[0], 1);
    check("after_rst_pr1", deq_pr[1], 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
